// File: rtl/aula_201029_qsys_s2m_pkg.sv
// Shared constants and types for the stream-to-memory writer: CSR map,
// STATUS bit positions, FSM state type and default geometry.
package aula_201029_qsys_s2m_pkg;

  localparam int unsigned DEFAULT_DATA_W      = 32;
  localparam int unsigned DEFAULT_ADDR_W      = 14;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 10240;

  localparam logic [1:0] CSR_CONTROL = 2'd0;
  localparam logic [1:0] CSR_BASE    = 2'd1;
  localparam logic [1:0] CSR_LENGTH  = 2'd2;
  localparam logic [1:0] CSR_STATUS  = 2'd3;

  localparam int CTRL_START_BIT     = 0;
  localparam int CTRL_ABORT_BIT     = 1;

  localparam int STAT_BUSY_BIT      = 0;
  localparam int STAT_DONE_BIT      = 1;
  localparam int STAT_WRAPPED_BIT   = 2;
  localparam int STAT_EARLY_EOP_BIT = 3;
  localparam int STAT_WORDS_LSB     = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } s2m_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/aula_201029_qsys_s2m_fifo.sv
// Synchronous first-word-fall-through buffer between the stream sink and the
// memory write port; head is served straight from the storage registers.
module aula_201029_qsys_s2m_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = store[rd_ptr];
  assign level   = count;

  // NOTE: storage is deliberately not reset; the count gates every read and
  // the top masks write data while idle, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aula_201029_qsys_stream_to_mem_writer.sv
// Avalon-ST sink to on-chip memory writer: CSR-programmed base/length, one
// buffered word per cycle written to a wrapping word address.
module aula_201029_qsys_stream_to_mem_writer
  import aula_201029_qsys_s2m_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  input  logic              snk_endofpacket,
  output logic              snk_ready,
  input  logic [1:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  s2m_state_e        state;
  s2m_state_e        state_next;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       length_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [15:0]       accepted_q;
  logic [15:0]       words_q;
  logic              done_q;
  logic              wrapped_q;
  logic              early_q;
  logic              clken_q;
  logic [31:0]       readdata_q;
  logic [31:0]       rd_mux;

  logic              ctrl_wr;
  logic              start;
  logic              abort;
  logic              busy;
  logic              accept;
  logic              last_word;
  logic              wr_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [DATA_W-1:0] fifo_head;
  logic              unused_bits;

  assign ctrl_wr     = csr_write && (csr_address == CSR_CONTROL);
  assign start       = ctrl_wr && csr_writedata[CTRL_START_BIT];
  assign abort       = ctrl_wr && csr_writedata[CTRL_ABORT_BIT];
  assign busy        = (state != S_IDLE);
  assign accept      = snk_valid && snk_ready;
  assign last_word   = ((accepted_q + 16'd1) == length_q);
  // Abort is combinational here so the write in its own cycle is already gone.
  assign wr_en       = busy && !fifo_empty && !abort;
  assign unused_bits = ^csr_writedata;

  aula_201029_qsys_s2m_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (accept),
    .push_data (snk_data),
    .pop       (wr_en),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    snk_ready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && (length_q != 16'd0)) state_next = S_RUN;
      end
      S_RUN: begin
        snk_ready = !fifo_full && !abort;
        if (accept && (last_word || snk_endofpacket)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty || (wr_en && fifo_level == LVL_W'(1))) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      length_q   <= '0;
      wptr_q     <= '0;
      accepted_q <= '0;
      words_q    <= '0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      early_q    <= 1'b0;
      clken_q    <= 1'b0;
    end else begin
      clken_q <= 1'b1;

      if ((state == S_IDLE) && csr_write) begin
        case (csr_address)
          CSR_BASE:   base_q   <= csr_writedata[ADDR_W-1:0];
          CSR_LENGTH: length_q <= csr_writedata[15:0];
          default:    ;
        endcase
      end

      if ((state == S_IDLE) && start && !abort) begin
        if (length_q != 16'd0) begin
          done_q     <= 1'b0;
          wrapped_q  <= 1'b0;
          early_q    <= 1'b0;
          words_q    <= '0;
          accepted_q <= '0;
          wptr_q     <= base_q;
        end else begin
          done_q <= 1'b1;
        end
      end

      if (accept) begin
        accepted_q <= accepted_q + 16'd1;
        if (snk_endofpacket && !last_word) early_q <= 1'b1;
      end

      if (wr_en) begin
        words_q <= sat_inc16(words_q);
        if (wptr_q == ADDR_W'(DEPTH_WORDS - 1)) begin
          wptr_q    <= '0;
          wrapped_q <= 1'b1;
        end else begin
          wptr_q <= wptr_q + ADDR_W'(1);
        end
      end

      if ((state == S_DRAIN) && (state_next == S_IDLE) && !abort) done_q <= 1'b1;
      if (abort) done_q <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_BASE:   rd_mux[ADDR_W-1:0] = base_q;
      CSR_LENGTH: rd_mux[15:0]       = length_q;
      CSR_STATUS: begin
        rd_mux[STAT_BUSY_BIT]      = busy;
        rd_mux[STAT_DONE_BIT]      = done_q;
        rd_mux[STAT_WRAPPED_BIT]   = wrapped_q;
        rd_mux[STAT_EARLY_EOP_BIT] = early_q;
        rd_mux[31:STAT_WORDS_LSB]  = words_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= csr_read ? rd_mux : 32'd0;
  end

  assign csr_readdata   = readdata_q;
  assign mem_chipselect = wr_en;
  assign mem_write      = wr_en;
  assign mem_byteenable = wr_en ? 4'hF : 4'h0;
  assign mem_writedata  = wr_en ? fifo_head : '0;
  assign mem_address    = wptr_q;
  assign mem_clken      = clken_q;

endmodule
